reg_file_2r1w: RTL

Dual-bank architectural register file: 32 integer (GPR) and 32 floating-point (FPR) registers, each 32 bits wide. It answers the decode stage's two combinational read requests and accepts one writeback per cycle. Writes are bypassed to same-cycle reads. A per-register pending scoreboard lets decode stall on operands whose producer has not yet written back. It sits between the decode stage (read side, issue side) and the writeback stage.

---
 rtl/reg_file_2r1w_pkg.sv | 19 +
 rtl/reg_file_2r1w_scoreboard.sv | 73 +++++++
 rtl/reg_file_2r1w.sv | 80 ++++++++
 3 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the dual-bank register file: bank encoding,
// register-number type and the GPR-zero helper.
package reg_file_2r1w_pkg;

  localparam int unsigned REG_NO_W = 5;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned XLEN_DEF = 32;

  localparam logic BANK_GPR = 1'b0;
  localparam logic BANK_FPR = 1'b1;

  typedef logic [REG_NO_W-1:0] reg_no_t;

  // GPR 0 is hardwired: never stored, never bypassed, never pending.
  function automatic logic is_zero_reg(logic fmode, reg_no_t no);
    return (fmode == BANK_GPR) && (no == reg_no_t'(0));
  endfunction

endpackage

// File: rtl/reg_file_2r1w_scoreboard.sv
// Pending-producer scoreboard: one bit per register per bank, with
// flush > issue-set > writeback-clear priority and combinational busy lookup.
module reg_scoreboard
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush_i,
  input  logic                issue_en_i,
  input  logic                issue_fmode_i,
  input  logic [REG_NO_W-1:0] issue_no_i,
  input  logic                wb_en_i,
  input  logic                wb_fmode_i,
  input  logic [REG_NO_W-1:0] wb_no_i,
  input  logic                rd1_fmode_i,
  input  logic [REG_NO_W-1:0] rd1_no_i,
  output logic                busy1_c_o,
  input  logic                rd2_fmode_i,
  input  logic [REG_NO_W-1:0] rd2_no_i,
  output logic                busy2_c_o
);

  logic [NREG-1:0] pend_g_q, pend_g_d;
  logic [NREG-1:0] pend_f_q, pend_f_d;

  // Clear first, then set, so a same-cycle issue keeps the bit pending.
  always_comb begin
    pend_g_d = pend_g_q;
    pend_f_d = pend_f_q;
    if (flush_i) begin
      pend_g_d = '0;
      pend_f_d = '0;
    end else begin
      if (wb_en_i) begin
        if (wb_fmode_i == BANK_FPR) pend_f_d[wb_no_i] = 1'b0;
        else                        pend_g_d[wb_no_i] = 1'b0;
      end
      if (issue_en_i && !is_zero_reg(issue_fmode_i, issue_no_i)) begin
        if (issue_fmode_i == BANK_FPR) pend_f_d[issue_no_i] = 1'b1;
        else                           pend_g_d[issue_no_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_g_q <= '0;
      pend_f_q <= '0;
    end else begin
      pend_g_q <= pend_g_d;
      pend_f_q <= pend_f_d;
    end
  end

  function automatic logic busy_of(logic f, logic [REG_NO_W-1:0] no,
                                   logic [NREG-1:0] pg, logic [NREG-1:0] pf,
                                   logic wen, logic wf, logic [REG_NO_W-1:0] wno);
    logic pend;
    pend = (f == BANK_FPR) ? pf[no] : pg[no];
    return pend && !(wen && (wf == f) && (wno == no));
  endfunction

  // A same-cycle writeback resolves the operand; a same-cycle issue does not.
  always_comb begin
    busy1_c_o = busy_of(rd1_fmode_i, rd1_no_i, pend_g_q, pend_f_q,
                        wb_en_i, wb_fmode_i, wb_no_i);
    busy2_c_o = busy_of(rd2_fmode_i, rd2_no_i, pend_g_q, pend_f_q,
                        wb_en_i, wb_fmode_i, wb_no_i);
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Dual-bank (GPR/FPR) register file with two combinational read ports,
// one writeback port with write-through bypass, and a pending scoreboard.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fmode1,
  input  logic [REG_NO_W-1:0] reg1,
  output logic [XLEN-1:0]     reg_out1,
  output logic                busy1,
  input  logic                fmode2,
  input  logic [REG_NO_W-1:0] reg2,
  output logic [XLEN-1:0]     reg_out2,
  output logic                busy2,
  input  logic                issue_enable,
  input  logic                issue_fmode,
  input  logic [REG_NO_W-1:0] issue_no,
  input  logic                wb_enable,
  input  logic                wb_fmode,
  input  logic [REG_NO_W-1:0] wb_no,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] fpr_q [NREG];
  logic            wr_en;

  assign wr_en = wb_enable && !is_zero_reg(wb_fmode, wb_no);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        gpr_q[i] <= '0;
        fpr_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (wb_fmode == BANK_FPR) fpr_q[wb_no] <= wb_data;
      else                      gpr_q[wb_no] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] rd_data(logic f, logic [REG_NO_W-1:0] no);
    if (is_zero_reg(f, no))
      return '0;
    if (wb_enable && (wb_fmode == f) && (wb_no == no))
      return wb_data;
    return (f == BANK_FPR) ? fpr_q[no] : gpr_q[no];
  endfunction

  always_comb begin
    reg_out1 = rd_data(fmode1, reg1);
    reg_out2 = rd_data(fmode2, reg2);
  end

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk           (clk),
    .rstn          (rstn),
    .flush_i       (flush),
    .issue_en_i    (issue_enable),
    .issue_fmode_i (issue_fmode),
    .issue_no_i    (issue_no),
    .wb_en_i       (wb_enable),
    .wb_fmode_i    (wb_fmode),
    .wb_no_i       (wb_no),
    .rd1_fmode_i   (fmode1),
    .rd1_no_i      (reg1),
    .busy1_c_o     (busy1),
    .rd2_fmode_i   (fmode2),
    .rd2_no_i      (reg2),
    .busy2_c_o     (busy2)
  );

endmodule
